// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared constants and helpers for regfile write-port arbiters
package regfile_write_arbiter_pkg;

   localparam int RF_AW = 4;
   localparam int RF_DW = 16;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_OWN  = 1'b1;

   // Next requester index in round-robin order.
   function automatic int wrap_inc(input int i, input int n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - requester-side write bus shared by all requesters
interface regfile_write_arbiter_if
   import regfile_write_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int AW   = RF_AW,
   parameter int DW   = RF_DW
);
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    lock;
   logic [NREQ*AW-1:0] waddr_in;
   logic [NREQ*DW-1:0] wdata_in;
   logic [NREQ-1:0]    gnt;

   modport master (output req, lock, waddr_in, wdata_in, input gnt);
   modport slave  (input req, lock, waddr_in, wdata_in, output gnt);
endinterface

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin picker: first req at or after ptr
module rr_priority_picker #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx,
   output logic          any
);
   always_comb begin
      int c;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      c   = 0;
      for (int k = 0; k < N; k++) begin
         c = (int'(ptr) + k) % N;
         if (!any && req[c]) begin
            any    = 1'b1;
            gnt[c] = 1'b1;
            idx    = PW'(c);
         end
      end
   end
endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin write-port arbiter with capped locked bursts
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int AW        = RF_AW,
   parameter int DW        = RF_DW,
   parameter int MAX_BURST = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   regfile_write_arbiter_if.slave bus,
   output logic                   rf_we,
   output logic [AW-1:0]          rf_waddr,
   output logic [DW-1:0]          rf_wdata,
   output logic                   busy
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int BW = $clog2(MAX_BURST + 1);

   logic [0:0]      state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   owner;
   logic [BW-1:0]   burst_cnt;
   logic [NREQ-1:0] pgnt;
   logic [PW-1:0]   pidx;
   logic            pany;
   logic [NREQ-1:0] gnt_c;
   logic [PW-1:0]   win;
   logic            accept;
   logic            last_beat;
   logic            locked_start;
   logic [PW-1:0]   owner_next;
   logic [PW-1:0]   pidx_next;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;

   rr_priority_picker #(.N(NREQ), .PW(PW)) u_picker (
      .req (bus.req),
      .ptr (ptr),
      .gnt (pgnt),
      .idx (pidx),
      .any (pany)
   );

   // While a burst is owned, every other requester is masked out.
   always_comb begin
      gnt_c = '0;
      win   = pidx;
      if (!rst_n) begin
         gnt_c = '0;
      end else if (state == ST_OWN) begin
         win = owner;
         if (bus.req[owner]) gnt_c[owner] = 1'b1;
      end else begin
         gnt_c = pgnt;
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == PW'(i)) begin
            sel_addr = bus.waddr_in[i*AW +: AW];
            sel_data = bus.wdata_in[i*DW +: DW];
         end
      end
   end

   assign bus.gnt      = gnt_c;
   assign accept       = |gnt_c;
   assign busy         = (state == ST_OWN);
   assign owner_next   = PW'(wrap_inc(int'(owner), NREQ));
   assign pidx_next    = PW'(wrap_inc(int'(pidx), NREQ));
   assign locked_start = bus.lock[pidx] && (MAX_BURST > 1);
   assign last_beat    = !bus.lock[owner] || (int'(burst_cnt) + 1 >= MAX_BURST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         owner     <= '0;
         burst_cnt <= '0;
      end else if (state == ST_IDLE) begin
         if (pany) begin
            if (locked_start) begin
               state     <= ST_OWN;
               owner     <= pidx;
               burst_cnt <= BW'(1);
            end else begin
               ptr <= pidx_next;
            end
         end
      end else begin
         // An owner dropping req forfeits the rest of its burst.
         if (!bus.req[owner] || last_beat) begin
            state     <= ST_IDLE;
            ptr       <= owner_next;
            burst_cnt <= '0;
         end else begin
            burst_cnt <= burst_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= accept;
         if (accept) begin
            rf_waddr <= sel_addr;
            rf_wdata <= sel_data;
         end
      end
   end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
   localparam int N  = 4;
   localparam int AW = 4;
   localparam int DW = 16;
   localparam int MB = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   regfile_write_arbiter_if #(.NREQ(N), .AW(AW), .DW(DW)) bus ();

   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          busy;

   regfile_write_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .rf_we    (rf_we),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata),
      .busy     (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: current burst owner (-1 = none), beats taken, next round-robin start.
   int            m_own;
   int            m_beats;
   int            m_rr;
   logic          exp_we;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_data;
   int            waitc [N];
   logic [DW-1:0] rf_mem [16];

   function automatic logic [N-1:0] model_gnt(input logic [N-1:0] r);
      if (m_own >= 0) return r[m_own] ? N'(1 << m_own) : '0;
      for (int k = 0; k < N; k++)
         if (r[(m_rr + k) % N]) return N'(1 << ((m_rr + k) % N));
      return '0;
   endfunction

   always @(posedge clk)
      if (rst_n && rf_we) rf_mem[rf_waddr] <= rf_wdata;

   always @(negedge clk) begin
      logic [N-1:0] eg;
      int w;
      if (!rst_n) begin
         m_own = -1; m_beats = 0; m_rr = 0;
         exp_we = 1'b0; exp_addr = '0; exp_data = '0;
         for (int i = 0; i < N; i++) waitc[i] = 0;
         chk("rst_gnt", bus.gnt, 0);
         chk("rst_we", rf_we, 0);
         chk("rst_waddr", rf_waddr, 0);
         chk("rst_wdata", rf_wdata, 0);
         chk("rst_busy", busy, 0);
      end else begin
         eg = model_gnt(bus.req);
         chk("gnt", bus.gnt, eg);
         chk("busy", busy, (m_own >= 0) ? 1 : 0);
         chk("rf_we", rf_we, exp_we);
         chk("rf_waddr", rf_waddr, exp_addr);
         chk("rf_wdata", rf_wdata, exp_data);
         for (int i = 0; i < N; i++) begin
            if (eg[i]) begin
               checks++;
               if (waitc[i] > (N - 1) * MB) begin
                  errors++;
                  $display("FAIL fair_wait: req%0d waited %0d cycles, limit %0d", i, waitc[i], (N - 1) * MB);
               end
               waitc[i] = 0;
            end else if (bus.req[i]) waitc[i]++;
            else waitc[i] = 0;
         end
         w = -1;
         for (int i = 0; i < N; i++) if (eg[i]) w = i;
         if (w >= 0) begin
            exp_we   = 1'b1;
            exp_addr = bus.waddr_in[w*AW +: AW];
            exp_data = bus.wdata_in[w*DW +: DW];
            if (m_own < 0) begin
               if (bus.lock[w] && MB > 1) begin m_own = w; m_beats = 1; end
               else m_rr = (w + 1) % N;
            end else begin
               m_beats++;
               if (!bus.lock[w] || m_beats >= MB) begin m_own = -1; m_rr = (w + 1) % N; end
            end
         end else begin
            exp_we = 1'b0;
            if (m_own >= 0) begin m_rr = (m_own + 1) % N; m_own = -1; end
         end
      end
   end

   task automatic at_edge();
      @(posedge clk); #2;
   endtask

   task automatic smp();
      @(negedge clk); #1;
   endtask

   task automatic set_beat(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.waddr_in[i*AW +: AW] = a;
      bus.wdata_in[i*DW +: DW] = d;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] acc;
      rst_n    = 1'b0;
      bus.req  = 4'hF;
      bus.lock = '0;
      for (int i = 0; i < N; i++) set_beat(i, AW'(i), 16'hA000 + 16'(i));

      // Reset with all requests pending.
      repeat (2) smp();
      chk("t1_gnt", bus.gnt, 0);
      chk("t1_we", rf_we, 0);
      chk("t1_waddr", rf_waddr, 0);
      chk("t1_wdata", rf_wdata, 0);
      at_edge();
      rst_n = 1'b1;

      // Plain round robin.
      for (int k = 0; k <= 8; k++) begin
         smp();
         if (k < 8) chk("t2_gnt", bus.gnt, 32'(1 << (k % 4)));
         if (k > 0) begin
            chk("t2_we", rf_we, 1);
            chk("t2_waddr", rf_waddr, (k - 1) % 4);
            chk("t2_wdata", rf_wdata, 16'hA000 + 16'((k - 1) % 4));
         end
         if (k == 7) begin at_edge(); bus.req = '0; end
      end

      // Locked burst capped at MB beats.
      at_edge();
      bus.req = 4'b0110; bus.lock = 4'b0010;
      for (int k = 0; k <= 4; k++) begin
         smp();
         chk("t3_gnt", bus.gnt, (k < 4) ? 32'h2 : 32'h4);
         chk("t3_busy", busy, (k >= 1 && k <= 3) ? 1 : 0);
      end
      at_edge();
      bus.req = '0; bus.lock = '0;

      // Owner releases early.
      at_edge();
      bus.req = 4'b1001; bus.lock = 4'b1000;
      smp(); chk("t4_gnt0", bus.gnt, 4'h8);
      smp(); chk("t4_gnt1", bus.gnt, 4'h8); chk("t4_busy1", busy, 1);
      at_edge();
      bus.req = 4'b0001; bus.lock = '0;
      smp(); chk("t4_gap", bus.gnt, 0);
      smp(); chk("t4_next", bus.gnt, 4'h1);
      at_edge();
      bus.req = '0;

      // Asynchronous reset in the middle of a burst.
      at_edge();
      bus.req = 4'b0010; bus.lock = 4'b0010;
      smp(); chk("t5_gnt0", bus.gnt, 4'h2);
      smp(); chk("t5_gnt1", bus.gnt, 4'h2);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_we", rf_we, 0);
      chk("t5_gnt", bus.gnt, 0);
      chk("t5_busy", busy, 0);
      @(negedge clk);
      at_edge();
      bus.req = 4'hF; bus.lock = '0;
      rst_n = 1'b1;
      smp(); chk("t5_first", bus.gnt, 4'h1);
      at_edge();
      bus.req = '0;

      // Contending writes land in the register file.
      at_edge();
      set_beat(0, 4'd0, 16'hAAAA);
      set_beat(1, 4'd1, 16'h5555);
      set_beat(2, 4'd2, 16'hF0F0);
      bus.req = 4'b0111; bus.lock = '0;
      for (int k = 0; k < 10 && bus.req != '0; k++) begin
         smp();
         acc = bus.gnt & bus.req;
         at_edge();
         bus.req = bus.req & ~acc;
      end
      chk("t6_drained", bus.req, 0);
      repeat (2) at_edge();
      chk("t6_r0", rf_mem[0], 16'hAAAA);
      chk("t6_r1", rf_mem[1], 16'h5555);
      chk("t6_r2", rf_mem[2], 16'hF0F0);

      // Random traffic following the requester rules.
      for (int c = 0; c < 3000; c++) begin
         smp();
         acc = bus.gnt & bus.req;
         at_edge();
         for (int i = 0; i < N; i++) begin
            if (acc[i] || !bus.req[i]) begin
               if ($urandom_range(3) != 0) begin
                  bus.req[i]  = 1'b1;
                  bus.lock[i] = ($urandom_range(2) == 0);
                  set_beat(i, AW'($urandom), DW'($urandom));
               end else begin
                  bus.req[i] = 1'b0;
               end
            end else if ($urandom_range(39) == 0) begin
               bus.req[i] = 1'b0;
            end
         end
      end
      bus.req = '0; bus.lock = '0;
      repeat (3) at_edge();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
